snake_step_ctrl: RTL and testbench
==================================

// Module: snake_step_ctrl
// PURPOSE
//  Game-tick sequencer for the snake core. Divides clk into move ticks and latches
//  button presses between ticks. Applies the direction-update rule once per tick and
//  issues one move request per tick to the body/move engine over a valid/ready
//  handshake. Runs the IDLE/RUN/DEAD game-state machine.
// PARAMETERS
//  TICK_DIV   16     clk cycles per move tick, >=2; counter width = $clog2(TICK_DIV)
//  START_DIR  2'b00  direction loaded in IDLE (00 right, 01 down, 10 left, 11 up)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous reset, active low
//  btn_up      in   1  debounced level, active high
//  btn_down    in   1  debounced level, active high
//  btn_left    in   1  debounced level, active high
//  btn_right   in   1  debounced level, active high
//  crash       in   1  level from collision logic, sampled in RUN only
//  step_ready  in   1  move engine accepts the current step
//  step_valid  out  1  move request pending; step_dir is the direction to apply
//  step_dir    out  2  current direction register (same encoding as START_DIR)
//  state       out  2  00 IDLE, 01 RUN, 10 DEAD (11 unused, never driven)
//  overrun     out  1  sticky: a tick arrived while a step was still pending
// BEHAVIOUR
//  Reset: state=IDLE, step_dir=START_DIR, step_valid=0, overrun=0, tick counter=0.
//   Pending-press register is empty and the released flag is 0.
//  Press latch: in each cycle where any button is high, the pending register takes
//   the highest-priority button asserted that cycle (up > down > left > right).
//   Later presses overwrite earlier ones (last press wins). Cleared when consumed.
//  Direction rule, applied on consumption only: new = pending.
//   If pending is empty, or pending is the 180-degree opposite of step_dir
//   (00<->10, 01<->11), step_dir is unchanged.
//  IDLE: counter held at 0; step_dir held at START_DIR.
//   Any button high -> RUN next cycle. That press is latched as pending.
//  RUN: counter increments every cycle, wrapping TICK_DIV-1 -> 0.
//   The tick is the cycle with counter == TICK_DIV-1.
//   On a tick with step_valid=0, the next edge sets step_valid=1, updates step_dir
//   per the direction rule, and clears pending. Latency: tick to request is 1 clk.
//   step_valid and step_dir are held stable until a cycle with step_ready=1.
//   step_valid falls on the edge after acceptance. The engine may hold step_ready
//   high, so back-to-back acceptance is legal.
//   On a tick with step_valid=1 and step_ready=0: no new request, pending is kept,
//   and overrun is set. overrun clears only on reset or on the IDLE->RUN transition.
//   A tick coinciding with acceptance (step_valid=1, step_ready=1) is not an overrun.
//   A new request is issued only on a later tick.
//  crash=1 in RUN -> DEAD next edge, with priority over a tick in the same cycle.
//   A pending step is aborted: step_valid drops to 0 next edge whatever step_ready is.
//  DEAD: step_valid=0, counter held at 0, step_dir frozen.
//   The released flag is set once all buttons are low.
//   Any button high with released=1 -> IDLE. Pending and released are cleared.
//  crash is ignored in IDLE and DEAD. Asynchronous reset in any state or mid-handshake
//   returns everything to reset values immediately.
// TESTING (TICK_DIV=4, START_DIR=00, step_ready=1 unless stated)
//  1. Reset, pulse btn_down 1 clk -> RUN. First tick at 4th RUN cycle; step_valid
//     for 1 clk with step_dir=01; next request exactly 4 clk later, step_dir=01.
//  2. In RUN with dir=00: press btn_left then no press -> step_dir stays 00.
//     Press btn_left and btn_up together -> step_dir=11 (priority and reversal rule).
//  3. Press btn_down then btn_up within one tick period, dir=00 -> step_dir=11
//     (last press wins).
//  4. Hold step_ready=0 across 2 ticks -> step_valid stays 1, step_dir stable,
//     overrun=1. Release ready -> one acceptance, next request at the next tick.
//  5. Assert crash on the tick cycle with step_valid pending -> state=10, step_valid=0
//     next edge. Held button does not leave DEAD; release then press -> IDLE,
//     step_dir=00.
//  6. Drop rst_n mid-request -> step_valid=0, state=00, overrun=0 without a clock edge.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// Game-tick sequencer for the snake core: divides clk into move ticks, latches
// button presses between ticks, issues one move request per tick and runs IDLE/RUN/DEAD.
module snake_step_ctrl #(
  parameter int unsigned TICK_DIV  = 16,
  parameter logic [1:0]  START_DIR = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       crash,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic [1:0] state,
  output logic       overrun
);

  localparam int unsigned    CW       = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 32'd1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  // Highest-priority button of this cycle: up > down > left > right.
  function automatic logic [1:0] press_dir(input logic up, input logic down,
                                           input logic left, input logic right);
    logic [1:0] dir;
    if (up) begin
      dir = 2'b11;
    end else if (down) begin
      dir = 2'b01;
    end else if (left) begin
      dir = 2'b10;
    end else if (right) begin
      dir = 2'b00;
    end else begin
      dir = 2'b00;
    end
    return dir;
  endfunction

  // Opposite directions differ only in the MSB (00<->10, 01<->11).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return ((a ^ b) == 2'b10);
  endfunction

  state_e         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           pend_vld_r, pend_vld_s;
  logic [1:0]     pend_dir_r, pend_dir_s;
  logic           released_r, released_s;
  logic           step_valid_r, step_valid_s;
  logic [1:0]     step_dir_r, step_dir_s;
  logic           overrun_r, overrun_s;

  logic           any_btn_s;
  logic [1:0]     btn_dir_s;
  logic           tick_s;
  logic           eff_vld_s;
  logic [1:0]     eff_dir_s;

  assign any_btn_s = btn_up | btn_down | btn_left | btn_right;
  assign btn_dir_s = press_dir(btn_up, btn_down, btn_left, btn_right);
  assign tick_s    = (cnt_r == CNT_LAST);
  // A press in the consuming cycle counts as the newest pending press.
  assign eff_vld_s = any_btn_s | pend_vld_r;
  assign eff_dir_s = any_btn_s ? btn_dir_s : pend_dir_r;

  // Next-state, counter, press latch and handshake decisions.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pend_vld_s   = pend_vld_r;
    pend_dir_s   = pend_dir_r;
    released_s   = released_r;
    step_valid_s = step_valid_r;
    step_dir_s   = step_dir_r;
    overrun_s    = overrun_r;

    case (state_r)
      ST_IDLE: begin
        cnt_s        = CNT_ZERO;
        step_dir_s   = START_DIR;
        step_valid_s = 1'b0;
        if (any_btn_s) begin
          state_s    = ST_RUN;
          pend_vld_s = 1'b1;
          pend_dir_s = btn_dir_s;
          overrun_s  = 1'b0;
        end else begin
          pend_vld_s = 1'b0;
        end
      end

      ST_RUN: begin
        if (crash) begin
          // Crash wins over a same-cycle tick and aborts any pending request.
          state_s      = ST_DEAD;
          cnt_s        = CNT_ZERO;
          step_valid_s = 1'b0;
          released_s   = 1'b0;
          pend_vld_s   = eff_vld_s;
          pend_dir_s   = eff_dir_s;
        end else begin
          cnt_s      = tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
          pend_vld_s = eff_vld_s;
          pend_dir_s = eff_dir_s;
          if (tick_s && !step_valid_r) begin
            step_valid_s = 1'b1;
            pend_vld_s   = 1'b0;
            if (eff_vld_s && !is_reverse(eff_dir_s, step_dir_r)) begin
              step_dir_s = eff_dir_s;
            end else begin
              step_dir_s = step_dir_r;
            end
          end else if (step_valid_r && step_ready) begin
            step_valid_s = 1'b0;
          end else begin
            step_valid_s = step_valid_r;
          end
          if (tick_s && step_valid_r && !step_ready) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
        end
      end

      ST_DEAD: begin
        cnt_s        = CNT_ZERO;
        step_valid_s = 1'b0;
        if (released_r && any_btn_s) begin
          state_s    = ST_IDLE;
          pend_vld_s = 1'b0;
          released_s = 1'b0;
          step_dir_s = START_DIR;
        end else if (!any_btn_s) begin
          released_s = 1'b1;
        end else begin
          released_s = released_r;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        cnt_s        = CNT_ZERO;
        pend_vld_s   = 1'b0;
        released_s   = 1'b0;
        step_valid_s = 1'b0;
        step_dir_s   = START_DIR;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      pend_vld_r   <= 1'b0;
      pend_dir_r   <= 2'b00;
      released_r   <= 1'b0;
      step_valid_r <= 1'b0;
      step_dir_r   <= START_DIR;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pend_vld_r   <= pend_vld_s;
      pend_dir_r   <= pend_dir_s;
      released_r   <= released_s;
      step_valid_r <= step_valid_s;
      step_dir_r   <= step_dir_s;
      overrun_r    <= overrun_s;
    end
  end

  assign step_valid = step_valid_r;
  assign step_dir   = step_dir_r;
  assign state      = state_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Self-checking bench for snake_step_ctrl: directed vector table, multi-cycle
// corner sequences and randomized stimulus against a behavioural game model.
module tb_snake_step_ctrl;

  localparam int unsigned TD = 4;
  localparam logic [1:0]  SD = 2'b00;

  logic       clk;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       crash;
  logic       step_ready;
  logic       step_valid;
  logic [1:0] step_dir;
  logic [1:0] state;
  logic       overrun;

  int total;
  int bad;

  snake_step_ctrl #(.TICK_DIV(TD), .START_DIR(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .crash      (crash),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .state      (state),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: game state 0 idle / 1 run / 2 dead, pending press -1 when empty.
  int m_state;
  int m_run_cyc;
  int m_pend;
  int m_dir;
  bit m_valid;
  bit m_over;
  bit m_rel;

  task automatic model_reset();
    m_state   = 0;
    m_run_cyc = 0;
    m_pend    = -1;
    m_dir     = int'(SD);
    m_valid   = 1'b0;
    m_over    = 1'b0;
    m_rel     = 1'b0;
  endtask

  // b = {up, down, left, right}
  function automatic int press_of(input logic [3:0] b);
    if (b[3]) return 3;
    if (b[2]) return 1;
    if (b[1]) return 2;
    if (b[0]) return 0;
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] b, input logic cr, input logic rd);
    int p;
    int eff;
    bit tick;
    bit was_valid;
    p = press_of(b);
    case (m_state)
      0: begin
        if (p >= 0) begin
          m_state   = 1;
          m_pend    = p;
          m_over    = 1'b0;
          m_run_cyc = 0;
        end
      end
      1: begin
        tick = ((m_run_cyc % TD) == (TD - 1));
        if (cr) begin
          m_state = 2;
          m_valid = 1'b0;
          m_rel   = 1'b0;
        end else begin
          eff       = (p >= 0) ? p : m_pend;
          was_valid = m_valid;
          m_run_cyc = m_run_cyc + 1;
          if (tick && !was_valid) begin
            if (eff >= 0 && eff != ((m_dir + 2) % 4)) m_dir = eff;
            m_valid = 1'b1;
            m_pend  = -1;
          end else begin
            m_pend = eff;
            if (was_valid && rd) m_valid = 1'b0;
            if (tick && was_valid && !rd) m_over = 1'b1;
          end
        end
      end
      default: begin
        if (m_rel && p >= 0) begin
          m_state = 0;
          m_pend  = -1;
          m_rel   = 1'b0;
          m_dir   = int'(SD);
        end else if (p < 0) begin
          m_rel = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},   int'(step_valid), int'(m_valid));
    check({tag, ".dir"},     int'(step_dir),   m_dir);
    check({tag, ".state"},   int'(state),      m_state);
    check({tag, ".overrun"}, int'(overrun),    int'(m_over));
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT, compare after the edge.
  task automatic step(input logic [3:0] b, input logic cr, input logic rd, input string tag);
    {btn_up, btn_down, btn_left, btn_right} = b;
    crash      = cr;
    step_ready = rd;
    model_update(b, cr, rd);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_valid"},   int'(step_valid), 0);
    check({tag, ".rst_state"},   int'(state),      0);
    check({tag, ".rst_overrun"}, int'(overrun),    0);
    check({tag, ".rst_dir"},     int'(step_dir),   int'(SD));
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    crash      = 1'b0;
    step_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       exp_valid;
    logic [1:0] exp_dir;
    logic [1:0] exp_state;
    logic       exp_over;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  task automatic set_vec(input int i, input logic [3:0] b, input logic v, input logic [1:0] d);
    tbl[i] = '{btn: b, exp_valid: v, exp_dir: d, exp_state: 2'b01, exp_over: 1'b0};
  endtask

  initial begin
    total = 0;
    bad   = 0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    crash      = 1'b0;
    step_ready = 1'b1;
    rst_n      = 1'b0;

    // Tick sequence, direction rule, priority and last-press-wins, ready held high.
    set_vec( 0, 4'b0100, 1'b0, 2'b00);
    set_vec( 1, 4'b0000, 1'b0, 2'b00);
    set_vec( 2, 4'b0000, 1'b0, 2'b00);
    set_vec( 3, 4'b0000, 1'b0, 2'b00);
    set_vec( 4, 4'b0000, 1'b1, 2'b01);
    set_vec( 5, 4'b0000, 1'b0, 2'b01);
    set_vec( 6, 4'b0000, 1'b0, 2'b01);
    set_vec( 7, 4'b0000, 1'b0, 2'b01);
    set_vec( 8, 4'b0000, 1'b1, 2'b01);
    set_vec( 9, 4'b0001, 1'b0, 2'b01);
    set_vec(10, 4'b0000, 1'b0, 2'b01);
    set_vec(11, 4'b0000, 1'b0, 2'b01);
    set_vec(12, 4'b0000, 1'b1, 2'b00);
    set_vec(13, 4'b0010, 1'b0, 2'b00);
    set_vec(14, 4'b0000, 1'b0, 2'b00);
    set_vec(15, 4'b0000, 1'b0, 2'b00);
    set_vec(16, 4'b0000, 1'b1, 2'b00);
    set_vec(17, 4'b0000, 1'b0, 2'b00);
    set_vec(18, 4'b0000, 1'b0, 2'b00);
    set_vec(19, 4'b1010, 1'b0, 2'b00);
    set_vec(20, 4'b0000, 1'b1, 2'b11);
    set_vec(21, 4'b0001, 1'b0, 2'b11);
    set_vec(22, 4'b0000, 1'b0, 2'b11);
    set_vec(23, 4'b0000, 1'b0, 2'b11);
    set_vec(24, 4'b0000, 1'b1, 2'b00);
    set_vec(25, 4'b0100, 1'b0, 2'b00);
    set_vec(26, 4'b1000, 1'b0, 2'b00);
    set_vec(27, 4'b0000, 1'b0, 2'b00);
    set_vec(28, 4'b0000, 1'b1, 2'b11);

    #12;
    do_reset("init");

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].btn, 1'b0, 1'b1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tvalid", i), int'(step_valid), int'(tbl[i].exp_valid));
      check($sformatf("vec%0d.tdir", i),   int'(step_dir),   int'(tbl[i].exp_dir));
      check($sformatf("vec%0d.tstate", i), int'(state),      int'(tbl[i].exp_state));
      check($sformatf("vec%0d.tover", i),  int'(overrun),    int'(tbl[i].exp_over));
    end

    // Back-pressure across two ticks: request held, overrun raised.
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0, 1'b0, "stall");
    check("stall.valid", int'(step_valid), 1);
    check("stall.dir",   int'(step_dir),   3);
    check("stall.over",  int'(overrun),    1);
    step(4'b0000, 1'b0, 1'b1, "accept");
    check("accept.valid", int'(step_valid), 0);
    step(4'b0000, 1'b0, 1'b1, "gap1");
    step(4'b0000, 1'b0, 1'b1, "gap2");
    check("gap2.valid", int'(step_valid), 0);
    step(4'b0000, 1'b0, 1'b1, "next_tick");
    check("next_tick.valid", int'(step_valid), 1);

    // Crash on a tick with a request pending; DEAD needs release before a press.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, "pend");
    step(4'b0000, 1'b1, 1'b0, "crash");
    check("crash.state", int'(state),      2);
    check("crash.valid", int'(step_valid), 0);
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1, "dead_held");
    check("dead_held.state", int'(state), 2);
    step(4'b0000, 1'b0, 1'b1, "dead_rel");
    check("dead_rel.state", int'(state), 2);
    step(4'b0010, 1'b0, 1'b1, "dead_exit");
    check("dead_exit.state", int'(state),    0);
    check("dead_exit.dir",   int'(step_dir), 0);

    // Asynchronous reset in the middle of a stalled request.
    step(4'b0001, 1'b0, 1'b0, "restart");
    check("restart.over", int'(overrun), 0);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0, 1'b0, "stall2");
    check("stall2.valid", int'(step_valid), 1);
    check("stall2.over",  int'(overrun),    1);
    #1;
    do_reset("midreq");

    // Randomized play checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      logic       cr;
      logic       rd;
      b[3] = ($urandom_range(0, 9) == 0);
      b[2] = ($urandom_range(0, 9) == 0);
      b[1] = ($urandom_range(0, 9) == 0);
      b[0] = ($urandom_range(0, 9) == 0);
      cr   = ($urandom_range(0, 29) == 0);
      rd   = ($urandom_range(0, 9) < 7);
      step(b, cr, rd, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
